data_sync: RTL

DATA_SYNC -- requirements
Module: data_sync

---
 rtl/data_sync_if.sv | 26 ++
 rtl/data_sync.sv | 86 ++++++++
 2 files changed

// File: rtl/data_sync_if.sv
// data_sync_if: source/destination signal bundle for data_sync.
// GLITCH_ERR is present only when DATA_SYNC_GLITCH_ERR_EN is defined.
interface data_sync_if #(
   parameter int BUS_WIDTH = 8,
   parameter int NUM_CTRL  = 4
);
   logic [BUS_WIDTH-1:0] UNSYNC_BUS;
   logic                 BUS_EN;
   logic [NUM_CTRL-1:0]  CTRL_ASYNC;
   logic [BUS_WIDTH-1:0] SYNC_BUS;
   logic                 ENABLE_PULSE;
   logic [NUM_CTRL-1:0]  CTRL_SYNC;
   logic                 BUSY;
`ifdef DATA_SYNC_GLITCH_ERR_EN
   logic                 GLITCH_ERR;
   modport master (output UNSYNC_BUS, BUS_EN, CTRL_ASYNC,
                   input SYNC_BUS, ENABLE_PULSE, CTRL_SYNC, BUSY, GLITCH_ERR);
   modport slave  (input UNSYNC_BUS, BUS_EN, CTRL_ASYNC,
                   output SYNC_BUS, ENABLE_PULSE, CTRL_SYNC, BUSY, GLITCH_ERR);
`else
   modport master (output UNSYNC_BUS, BUS_EN, CTRL_ASYNC,
                   input SYNC_BUS, ENABLE_PULSE, CTRL_SYNC, BUSY);
   modport slave  (input UNSYNC_BUS, BUS_EN, CTRL_ASYNC,
                   output SYNC_BUS, ENABLE_PULSE, CTRL_SYNC, BUSY);
`endif
endinterface

// File: rtl/data_sync.sv
// data_sync: level-qualified bus capture across clock domains with stability filter and control synchronisers.
// Optional sticky glitch flag enabled by macro DATA_SYNC_GLITCH_ERR_EN.
module data_sync #(
   parameter int BUS_WIDTH     = 8,
   parameter int NUM_STAGES    = 2,
   parameter int STABLE_CYCLES = 1,
   parameter int NUM_CTRL      = 4
) (
   input logic       CLK,
   input logic       RST,
   data_sync_if.slave bus
);
   typedef enum logic [1:0] {IDLE, STABLE, WAIT_LOW} state_t;
   localparam logic [3:0] SC = 4'(STABLE_CYCLES);
   state_t                               r_state;
   logic [NUM_STAGES-1:0]                r_en_sync;
   logic [NUM_STAGES-1:0][NUM_CTRL-1:0]  r_ctrl_sync;
   logic [3:0]                           r_cnt;
   logic [BUS_WIDTH-1:0]                 r_sync_bus;
   logic                                 r_pulse;
   logic                                 r_busy;
   logic                                 w_en_s;
   logic [3:0]                           w_cnt_nxt;
   assign w_en_s           = r_en_sync[NUM_STAGES-1];
   assign w_cnt_nxt        = r_cnt + 4'd1;
   assign bus.SYNC_BUS     = r_sync_bus;
   assign bus.ENABLE_PULSE = r_pulse;
   assign bus.CTRL_SYNC    = r_ctrl_sync[NUM_STAGES-1];
   assign bus.BUSY         = r_busy;
   // UNSYNC_BUS is deliberately not synchronised: the source holds it while BUS_EN is high
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state     <= IDLE;
         r_en_sync   <= '0;
         r_ctrl_sync <= '0;
         r_cnt       <= '0;
         r_sync_bus  <= '0;
         r_pulse     <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_en_sync   <= {r_en_sync[NUM_STAGES-2:0], bus.BUS_EN};
         r_ctrl_sync <= {r_ctrl_sync[NUM_STAGES-2:0], bus.CTRL_ASYNC};
         r_pulse     <= 1'b0;
         case (r_state)
            IDLE: if (w_en_s) begin
               r_cnt  <= 4'd1;
               r_busy <= 1'b1;
               if (SC == 4'd1) begin
                  r_sync_bus <= bus.UNSYNC_BUS;
                  r_pulse    <= 1'b1;
                  r_state    <= WAIT_LOW;
               end else
                  r_state <= STABLE;
            end
            STABLE: if (w_en_s) begin
               r_cnt <= w_cnt_nxt;
               if (w_cnt_nxt == SC) begin
                  r_sync_bus <= bus.UNSYNC_BUS;
                  r_pulse    <= 1'b1;
                  r_state    <= WAIT_LOW;
               end
            end else begin
               r_cnt   <= '0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            WAIT_LOW: if (!w_en_s) begin
               r_cnt   <= '0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
`ifdef DATA_SYNC_GLITCH_ERR_EN
   logic r_glitch;
   assign bus.GLITCH_ERR = r_glitch;
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         r_glitch <= 1'b0;
      else if (r_state == STABLE && !w_en_s)
         r_glitch <= 1'b1;
   end
`endif
endmodule
